// File: rtl/stream_upsizer.sv
// Width upsizer: packs SCALE consecutive DW_IN-bit stream words into one DW_IN*SCALE-bit word,
// little-endian, with full-rate throughput and a registered master side.
module stream_upsizer #(
    parameter int DW_IN = 16,
    parameter int SCALE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW_IN-1:0]       s_data_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    output logic [DW_IN*SCALE-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);

    localparam int              DW_OUT   = DW_IN * SCALE;
    localparam int              CW       = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(SCALE - 1);

    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic [DW_OUT-1:0] acc_r;
    logic [DW_OUT-1:0] acc_nxt_s;
    logic [DW_OUT-1:0] acc_ins_s;
    logic [DW_OUT-1:0] data_r;
    logic [DW_OUT-1:0] data_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              last_s;
    logic              ready_s;
    logic              in_xfer_s;
    logic              out_xfer_s;

    // Handshake decode; ready never looks at s_valid_i, only at counter and output slot.
    always_comb begin
        last_s     = (cnt_r == LAST_IDX);
        ready_s    = !last_s || !valid_r || m_ready_i;
        in_xfer_s  = s_valid_i && ready_s;
        out_xfer_s = valid_r && m_ready_i;
    end

    // Accumulated words with the incoming word dropped into the slot selected by the counter.
    always_comb begin
        acc_ins_s = acc_r;
        for (int k = 0; k < SCALE; k++) begin
            acc_ins_s[k*DW_IN +: DW_IN] = (cnt_r == CW'(k)) ? s_data_i : acc_r[k*DW_IN +: DW_IN];
        end
    end

    // Next-state: final word loads the output slot directly, earlier words go to the accumulator.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        acc_nxt_s   = acc_r;
        data_nxt_s  = data_r;
        valid_nxt_s = valid_r;
        if (in_xfer_s && last_s) begin
            cnt_nxt_s   = {CW{1'b0}};
            data_nxt_s  = acc_ins_s;
            valid_nxt_s = 1'b1;
        end else if (in_xfer_s) begin
            cnt_nxt_s = cnt_r + CW'(1);
            acc_nxt_s = acc_ins_s;
            if (out_xfer_s) begin
                valid_nxt_s = 1'b0;
            end else begin
                valid_nxt_s = valid_r;
            end
        end else if (out_xfer_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State registers; reset drops any partial word and any pending output word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {DW_OUT{1'b0}};
            data_r  <= {DW_OUT{1'b0}};
            valid_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_nxt_s;
            acc_r   <= acc_nxt_s;
            data_r  <= data_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign s_ready_o = ready_s;
    assign m_data_o  = data_r;
    assign m_valid_o = valid_r;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed/random bench for stream_upsizer (DW_IN=16, SCALE=3) with a queue scoreboard
// fed from accepted input words and drained by a negedge output monitor.
module tb_stream_upsizer;

    localparam int DW_IN  = 16;
    localparam int SCALE  = 3;
    localparam int DW_OUT = DW_IN * SCALE;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DW_IN-1:0]  s_data_i = '0;
    logic              s_valid_i = 1'b0;
    logic              s_ready_o;
    logic [DW_OUT-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i = 1'b0;

    logic [DW_OUT-1:0] exp_q[$];
    logic [DW_OUT-1:0] pack_r = '0;
    int                k_idx = 0;
    int                n_assert = 0;
    int                n_fail = 0;
    int                n_out = 0;
    logic              hold_r = 1'b0;
    logic [DW_OUT-1:0] hold_data = '0;

    stream_upsizer #(.DW_IN(DW_IN), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW_OUT-1:0] obs, input logic [DW_OUT-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [DW_IN-1:0] d);
        pack_r[k_idx*DW_IN +: DW_IN] = d;
        k_idx++;
        if (k_idx == SCALE) begin
            exp_q.push_back(pack_r);
            k_idx = 0;
        end
    endtask

    // One cycle: drive after the edge, decide acceptance at negedge, return just after next edge.
    task automatic step(input logic v, input logic [DW_IN-1:0] d, input logic r, output logic acc);
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
        @(negedge clk);
        acc = v && s_ready_o;
        if (acc) accept(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW_IN-1:0] d, input logic r);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            step(1'b1, d, r, acc);
            n++;
        end
        check("send_accept", DW_OUT'(acc), DW_OUT'(1));
    endtask

    // Output monitor: scoreboard pop on each output transfer, stability check under backpressure.
    always @(negedge clk) begin
        if (!rst) begin
            hold_r <= 1'b0;
        end else begin
            if (hold_r) begin
                check("hold_valid", DW_OUT'(m_valid_o), DW_OUT'(1));
                check("hold_data", m_data_o, hold_data);
            end
            if (m_valid_o && m_ready_i) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_output observed=%h expected=none", m_data_o);
                end
                if (exp_q.size() != 0) begin
                    check("out_data", m_data_o, exp_q.pop_front());
                    n_out++;
                end
            end
            hold_r    <= m_valid_o && !m_ready_i;
            hold_data <= m_data_o;
        end
    end

    initial begin
        logic              acc;
        logic [DW_IN-1:0]  cur;
        int                sent;
        int                cyc;

        // Reset held for 10 cycles
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_valid", DW_OUT'(m_valid_o), DW_OUT'(0));
        check("rst_data", m_data_o, DW_OUT'(0));
        check("rst_ready", DW_OUT'(s_ready_o), DW_OUT'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic packing and latency
        send(16'h1111, 1'b1);
        send(16'h2222, 1'b1);
        check("no_early_valid", DW_OUT'(m_valid_o), DW_OUT'(0));
        send(16'h3333, 1'b1);
        check("pack_valid", DW_OUT'(m_valid_o), DW_OUT'(1));
        check("pack_data", m_data_o, 48'h333322221111);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("pack_drained", DW_OUT'(exp_q.size()), DW_OUT'(0));

        // Full-rate stream
        n_out = 0;
        for (int i = 0; i < 9000; i++) begin
            step(1'b1, DW_IN'($urandom), 1'b1, acc);
            if (acc !== 1'b1) check("full_rate_ready", DW_OUT'(acc), DW_OUT'(1));
        end
        step(1'b0, 16'h0000, 1'b1, acc);
        check("full_rate_outputs", DW_OUT'(n_out), DW_OUT'(3000));

        // Backpressure after the first output word
        send(16'hA000, 1'b1);
        send(16'hA001, 1'b1);
        send(16'hA002, 1'b1);
        send(16'hA003, 1'b0);
        send(16'hA004, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'hA005, 1'b0, acc);
            check("bp_stall", DW_OUT'(acc), DW_OUT'(0));
        end
        step(1'b1, 16'hA005, 1'b1, acc);
        check("bp_resume", DW_OUT'(acc), DW_OUT'(1));
        check("bp_no_bubble", DW_OUT'(m_valid_o), DW_OUT'(1));
        send(16'hA006, 1'b1);
        send(16'hA007, 1'b1);
        send(16'hA008, 1'b1);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("bp_drained", DW_OUT'(exp_q.size()), DW_OUT'(0));

        // Random throttling: write rate 0.5, read rate 0.3
        n_out = 0;
        sent  = 0;
        cyc   = 0;
        cur   = DW_IN'($urandom);
        while (n_out < 3000 && cyc < 60000) begin
            step((sent < 9000) && ($urandom_range(0, 1) == 1), cur,
                 ($urandom_range(0, 9) < 3), acc);
            if (acc) begin
                sent++;
                cur = DW_IN'($urandom);
            end
            cyc++;
        end
        check("throttle_outputs", DW_OUT'(n_out), DW_OUT'(3000));
        check("throttle_drained", DW_OUT'(exp_q.size()), DW_OUT'(0));

        // Reset in the middle of a word
        send(16'h1234, 1'b1);
        send(16'h5678, 1'b1);
        rst   = 1'b0;
        k_idx = 0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", DW_OUT'(m_valid_o), DW_OUT'(0));
        check("midrst_ready", DW_OUT'(s_ready_o), DW_OUT'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(16'h000A, 1'b1);
        send(16'h000B, 1'b1);
        send(16'h000C, 1'b1);
        check("midrst_out_valid", DW_OUT'(m_valid_o), DW_OUT'(1));
        check("midrst_out_data", m_data_o, 48'h000C000B000A);
        step(1'b0, 16'h0000, 1'b1, acc);
        check("final_drained", DW_OUT'(exp_q.size()), DW_OUT'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
